// File: rtl/fir_pkg.sv
// Shared encodings and constants for the FIR sequencing controller.
// Optional tlast checking is enabled with FIR_TLAST_CHECK_EN (see fir_seq_ctrl).
package fir_pkg;
  localparam int          Tape_Num      = 11;
  localparam logic [11:0] ADDR_AP_CTRL  = 12'h00;
  localparam logic [11:0] ADDR_DATA_LEN = 12'h10;
  localparam logic [11:0] ADDR_TAP_BASE = 12'h20;
  localparam logic [3:0]  WE_ALL        = 4'hf;

  typedef enum logic [2:0] {
    S_IDLE, S_CLEAR, S_WAIT_IN, S_WRITE, S_MAC, S_OUT, S_DONE
  } fir_state_e;

  // BRAMs are 32-bit word addressed through a byte address
  function automatic logic [11:0] word_addr(input logic [3:0] w);
    return {6'd0, w, 2'b00};
  endfunction
endpackage

// File: rtl/fir_seq_ctrl_if.sv
// Stream handshakes, BRAM ports and MAC strobes between controller and FIR datapath.
interface fir_seq_ctrl_if #(parameter int pADDR_WIDTH = 12);
  logic                   ss_tvalid, ss_tlast, ss_tready, sample_ld;
  logic                   sm_tready, sm_tvalid, sm_tlast;
  logic                   tap_EN;
  logic [pADDR_WIDTH-1:0] tap_A;
  logic                   data_EN;
  logic [3:0]             data_WE;
  logic [pADDR_WIDTH-1:0] data_A;
  logic                   mac_en, mac_first;

  modport master (
    input  ss_tvalid, ss_tlast, sm_tready,
    output ss_tready, sample_ld, sm_tvalid, sm_tlast,
           tap_EN, tap_A, data_EN, data_WE, data_A, mac_en, mac_first
  );
  modport slave (
    output ss_tvalid, ss_tlast, sm_tready,
    input  ss_tready, sample_ld, sm_tvalid, sm_tlast,
           tap_EN, tap_A, data_EN, data_WE, data_A, mac_en, mac_first
  );
endinterface

// File: rtl/fir_ring_ptr.sv
// Modulo-DEPTH head pointer of the data ring, plus (head - ofs) mod DEPTH for tap walks.
module fir_ring_ptr #(
  parameter int DEPTH = 11,
  parameter int W     = 4
) (
  input  logic         axis_clk,
  input  logic         axis_rst,
  input  logic         clr,
  input  logic         inc,
  input  logic [W-1:0] ofs,
  output logic [W-1:0] ptr,
  output logic [W-1:0] ptr_sub
);
  always_ff @(posedge axis_clk) begin
    if (axis_rst || clr)
      ptr <= '0;
    else if (inc)
      ptr <= (ptr == W'(DEPTH - 1)) ? '0 : ptr + W'(1);
  end

  assign ptr_sub = (ptr >= ofs) ? ptr - ofs : W'(DEPTH) - ofs + ptr;
endmodule

// File: rtl/fir_seq_ctrl.sv
// FIR sequencing controller: ap_* lifecycle, AXIS handshakes, BRAM ring scheduling, MAC strobes.
// Define FIR_TLAST_CHECK_EN to flag ss_tlast disagreeing with data_length on tlast_err.
module fir_seq_ctrl
  import fir_pkg::*;
#(
  parameter int pADDR_WIDTH = 12,
  parameter int pLEN_WIDTH  = 32
) (
  input  logic                  axis_clk,
  input  logic                  axis_rst,
  input  logic                  ap_start,
  input  logic [pLEN_WIDTH-1:0] data_length,
  input  logic                  done_clr,
  output logic                  ap_done,
  output logic                  ap_idle,
  output logic                  cfg_lock,
  output logic                  tlast_err,
  fir_seq_ctrl_if.master        s
);
  localparam int PW = $clog2(Tape_Num + 1);

  fir_state_e            state, nxt;
  logic [PW-1:0]         idx, head, ring_a;
  logic [pLEN_WIDTH-1:0] len_q, count;
  logic                  start, ss_hs, sm_hs, last, issue;

  assign start = (state == S_IDLE) && ap_start;
  assign ss_hs = (state == S_WAIT_IN) && s.ss_tvalid;
  assign sm_hs = (state == S_OUT) && s.sm_tready;
  assign last  = (count == len_q - pLEN_WIDTH'(1));
  assign issue = (state == S_MAC) && (idx != PW'(Tape_Num));

  fir_ring_ptr #(.DEPTH(Tape_Num), .W(PW)) u_ring (
    .axis_clk (axis_clk),
    .axis_rst (axis_rst),
    .clr      (start),
    .inc      (sm_hs),
    .ofs      (idx),
    .ptr      (head),
    .ptr_sub  (ring_a)
  );

  always_ff @(posedge axis_clk) begin
    if (axis_rst) state <= S_IDLE;
    else          state <= nxt;
  end

  always_comb begin
    nxt = state;
    case (state)
      S_IDLE:    if (ap_start) nxt = S_CLEAR;
      S_CLEAR:   if (idx == PW'(Tape_Num - 1))
                   nxt = (len_q == '0) ? S_DONE : S_WAIT_IN;
      S_WAIT_IN: if (ss_hs) nxt = S_WRITE;
      S_WRITE:   nxt = S_MAC;
      S_MAC:     if (idx == PW'(Tape_Num)) nxt = S_OUT;
      S_OUT:     if (sm_hs) nxt = last ? S_DONE : S_WAIT_IN;
      S_DONE:    nxt = S_IDLE;
      default:   nxt = S_IDLE;
    endcase
  end

  // idx walks the ring in CLEAR and the taps in MAC (one extra cycle drains the BRAM)
  always_ff @(posedge axis_clk) begin
    if (axis_rst) begin
      idx       <= '0;
      len_q     <= '0;
      count     <= '0;
      ap_done   <= 1'b0;
      s.mac_en    <= 1'b0;
      s.mac_first <= 1'b0;
    end else begin
      idx <= ((state == S_CLEAR || state == S_MAC) && nxt == state) ? idx + PW'(1) : '0;
      if (start) begin
        len_q <= data_length;
        count <= '0;
      end else if (sm_hs) begin
        count <= count + pLEN_WIDTH'(1);
      end
      if (state == S_DONE)       ap_done <= 1'b1;
      else if (start || done_clr) ap_done <= 1'b0;
      s.mac_en    <= issue;
      s.mac_first <= issue && (idx == '0);
    end
  end

  always_comb begin
    s.ss_tready = (state == S_WAIT_IN);
    s.sample_ld = ss_hs;
    s.sm_tvalid = (state == S_OUT);
    s.sm_tlast  = (state == S_OUT) && last;
    s.tap_EN    = issue;
    s.tap_A     = '0;
    s.data_EN   = 1'b0;
    s.data_WE   = '0;
    s.data_A    = '0;
    case (state)
      S_CLEAR: begin
        s.data_EN = 1'b1;
        s.data_WE = WE_ALL;
        s.data_A  = pADDR_WIDTH'(word_addr(idx));
      end
      S_WRITE: begin
        s.data_EN = 1'b1;
        s.data_WE = WE_ALL;
        s.data_A  = pADDR_WIDTH'(word_addr(head));
      end
      S_MAC: if (issue) begin
        s.data_EN = 1'b1;
        s.tap_A   = pADDR_WIDTH'(word_addr(idx));
        s.data_A  = pADDR_WIDTH'(word_addr(ring_a));
      end
      default: ;
    endcase
  end

  assign ap_idle  = (state == S_IDLE);
  assign cfg_lock = !ap_idle;

`ifdef FIR_TLAST_CHECK_EN
  always_ff @(posedge axis_clk) begin
    if (axis_rst)                          tlast_err <= 1'b0;
    else if (start)                        tlast_err <= 1'b0;
    else if (ss_hs && (s.ss_tlast != last)) tlast_err <= 1'b1;
  end
`else
  logic unused_tlast;
  assign unused_tlast = s.ss_tlast;
  assign tlast_err    = 1'b0;
`endif
endmodule

// File: tb/tb_fir_seq_ctrl.sv
// Randomized cycle-level bench for fir_seq_ctrl against a per-sample schedule model.
module tb_fir_seq_ctrl;
  import fir_pkg::*;

  logic        axis_clk = 1'b0;
  logic        axis_rst, ap_start, done_clr;
  logic [31:0] data_length;
  logic        ap_done, ap_idle, cfg_lock, tlast_err;
  int          n_chk = 0, n_err = 0;
  bit          exp_err;

`ifdef FIR_TLAST_CHECK_EN
  localparam bit TCHK = 1'b1;
`else
  localparam bit TCHK = 1'b0;
`endif

  fir_seq_ctrl_if #(.pADDR_WIDTH(12)) bus ();

  fir_seq_ctrl #(.pADDR_WIDTH(12), .pLEN_WIDTH(32)) dut (
    .axis_clk    (axis_clk),
    .axis_rst    (axis_rst),
    .ap_start    (ap_start),
    .data_length (data_length),
    .done_clr    (done_clr),
    .ap_done     (ap_done),
    .ap_idle     (ap_idle),
    .cfg_lock    (cfg_lock),
    .tlast_err   (tlast_err),
    .s           (bus)
  );

  always #5 axis_clk = ~axis_clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h @%0t", tag, got, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge axis_clk);
    #1;
  endtask

  // One run: bad_n flips ss_tlast on that sample, stall_n holds sm_tready low 5 cycles,
  // abort_n pulses axis_rst mid-MAC, clr_at_done raises done_clr in the DONE cycle.
  task automatic run(input int len, input int bad_n, input int stall_n,
                     input int abort_n, input bit clr_at_done);
    int  h, gap, ns;
    bit  tl;
    bus.ss_tvalid = 1'b0;
    ap_start = 1'b1;
    data_length = len;
    #1;
    chk("idle_before_start", ap_idle, 1);
    step();
    ap_start = 1'b0;
    exp_err = 1'b0;
    data_length = $urandom;
    for (int i = 0; i < Tape_Num; i++) begin
      ap_start = (i == 3);
      #1;
      chk("clr_en", bus.data_EN, 1);
      chk("clr_we", bus.data_WE, 4'hf);
      chk("clr_a", bus.data_A, 4 * i);
      chk("clr_lock", cfg_lock, 1);
      chk("clr_done", ap_done, 0);
      chk("clr_tready", bus.ss_tready, 0);
      step();
    end
    ap_start = 1'b0;
    if (len == 0) begin
      #1;
      chk("z_done_cyc", ap_done, 0);
      chk("z_idle_cyc", ap_idle, 0);
      chk("z_tready", bus.ss_tready, 0);
      step();
      chk("z_idle", ap_idle, 1);
      chk("z_done", ap_done, 1);
      return;
    end
    for (int n = 0; n < len; n++) begin
      h = n % Tape_Num;
      gap = $urandom_range(0, 3);
      for (int g = 0; g < gap; g++) begin
        bus.ss_tvalid = 1'b0;
        #1;
        chk("wait_tready", bus.ss_tready, 1);
        chk("wait_ld", bus.sample_ld, 0);
        chk("wait_den", bus.data_EN, 0);
        chk("wait_mac", bus.mac_en, 0);
        step();
      end
      tl = (n == len - 1) ^ (n == bad_n);
      bus.ss_tvalid = 1'b1;
      bus.ss_tlast = tl;
      if (TCHK && tl != (n == len - 1)) exp_err = 1'b1;
      #1;
      chk("hs_tready", bus.ss_tready, 1);
      chk("hs_ld", bus.sample_ld, 1);
      step();
      bus.ss_tvalid = 1'($urandom);
      #1;
      chk("wr_en", bus.data_EN, 1);
      chk("wr_we", bus.data_WE, 4'hf);
      chk("wr_a", bus.data_A, 4 * h);
      chk("wr_tready", bus.ss_tready, 0);
      chk("wr_ld", bus.sample_ld, 0);
      chk("wr_mac", bus.mac_en, 0);
      chk("tlast_err", tlast_err, exp_err);
      step();
      for (int k = 0; k < Tape_Num; k++) begin
        #1;
        chk("mac_tap_en", bus.tap_EN, 1);
        chk("mac_tap_a", bus.tap_A, 4 * k);
        chk("mac_den", bus.data_EN, 1);
        chk("mac_dwe", bus.data_WE, 0);
        chk("mac_da", bus.data_A, 4 * ((h - k + Tape_Num) % Tape_Num));
        chk("mac_en", bus.mac_en, k > 0);
        chk("mac_first", bus.mac_first, k == 1);
        if (n == abort_n && k == 5) begin
          axis_rst = 1'b1;
          step();
          axis_rst = 1'b0;
          #1;
          chk("abort_idle", ap_idle, 1);
          chk("abort_mac", bus.mac_en, 0);
          chk("abort_tap", bus.tap_EN, 0);
          chk("abort_den", bus.data_EN, 0);
          chk("abort_done", ap_done, 0);
          chk("abort_err", tlast_err, 0);
          return;
        end
        step();
      end
      #1;
      chk("drain_mac", bus.mac_en, 1);
      chk("drain_first", bus.mac_first, 0);
      chk("drain_tap", bus.tap_EN, 0);
      chk("drain_tvalid", bus.sm_tvalid, 0);
      step();
      ns = (n == stall_n) ? 5 : $urandom_range(0, 2);
      for (int st = 0; st < ns; st++) begin
        bus.sm_tready = 1'b0;
        bus.ss_tvalid = 1'($urandom);
        #1;
        chk("out_tvalid", bus.sm_tvalid, 1);
        chk("out_tlast", bus.sm_tlast, n == len - 1);
        chk("out_tready", bus.ss_tready, 0);
        chk("out_ld", bus.sample_ld, 0);
        step();
      end
      bus.sm_tready = 1'b1;
      bus.ss_tvalid = 1'b0;
      #1;
      chk("ohs_tvalid", bus.sm_tvalid, 1);
      chk("ohs_tlast", bus.sm_tlast, n == len - 1);
      step();
      bus.sm_tready = 1'b0;
    end
    done_clr = clr_at_done;
    #1;
    chk("done_cyc", ap_done, 0);
    chk("done_cyc_idle", ap_idle, 0);
    chk("done_cyc_tvalid", bus.sm_tvalid, 0);
    step();
    done_clr = 1'b0;
    #1;
    chk("end_done", ap_done, 1);
    chk("end_idle", ap_idle, 1);
    chk("end_lock", cfg_lock, 0);
    chk("end_err", tlast_err, exp_err);
  endtask

  task automatic clear_done();
    for (int i = 0; i < 3; i++) begin
      step();
      chk("done_sticky", ap_done, 1);
    end
    done_clr = 1'b1;
    step();
    done_clr = 1'b0;
    #1;
    chk("done_clr", ap_done, 0);
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    axis_rst = 1'b1;
    ap_start = 1'b0;
    done_clr = 1'b0;
    data_length = '0;
    bus.ss_tvalid = 1'b0;
    bus.ss_tlast = 1'b0;
    bus.sm_tready = 1'b0;
    exp_err = 1'b0;
    repeat (3) step();
    chk("rst_idle", ap_idle, 1);
    chk("rst_done", ap_done, 0);
    chk("rst_tready", bus.ss_tready, 0);
    chk("rst_tvalid", bus.sm_tvalid, 0);
    chk("rst_tap_en", bus.tap_EN, 0);
    chk("rst_den", bus.data_EN, 0);
    chk("rst_dwe", bus.data_WE, 0);
    chk("rst_mac", bus.mac_en, 0);
    chk("rst_lock", cfg_lock, 0);
    chk("rst_err", tlast_err, 0);
    axis_rst = 1'b0;
    step();

    run(3, -1, -1, -1, 1'b0);
    clear_done();
    run(14, -1, 1, -1, 1'b0);
    run(0, -1, -1, -1, 1'b0);
    clear_done();
    run(5, -1, -1, 2, 1'b0);
    step();
    run(600, 5, -1, -1, 1'b1);
    clear_done();

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
